// File: rtl/easyaxi_ost_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | easyaxi_ost_alloc: lowest-free outstanding-slot allocator with release,   |
// | occupancy count, per-slot ID readback. Option: EASYAXI_OST_ALLOC_LEN_CHECK_EN |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module easyaxi_ost_alloc #(
    parameter  int OST_DEPTH = 16,
    parameter  int ID_WIDTH  = 4,
    parameter  int LEN_WIDTH = 8,
    localparam int PTR_WIDTH = $clog2(OST_DEPTH),
    localparam int CNT_WIDTH = PTR_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [ID_WIDTH-1:0]  req_id,
    input  logic [LEN_WIDTH-1:0] req_len,
    output logic                 req_ready,
    output logic [PTR_WIDTH-1:0] req_ptr,
    input  logic                 resp_valid,
    input  logic                 resp_ready,
    input  logic [PTR_WIDTH-1:0] resp_ptr,
    input  logic                 resp_last,
    output logic [OST_DEPTH-1:0] ost_bits,
    output logic [CNT_WIDTH-1:0] ost_cnt,
    output logic [ID_WIDTH-1:0]  slot_id,
    output logic                 len_err
);

    logic [OST_DEPTH-1:0] ost_bits_q, ost_bits_d;
    logic [CNT_WIDTH-1:0] ost_cnt_q, ost_cnt_d;
    logic [ID_WIDTH-1:0]  slot_id_q [OST_DEPTH];
    logic [PTR_WIDTH-1:0] free_ptr;
    logic                 alloc;
    logic                 beat_acc;
    logic                 release_ev;

    // Scan downward so the lowest clear bit is the last one written.
    always_comb begin
        free_ptr = '0;
        for (int i = OST_DEPTH - 1; i >= 0; i--) begin
            if (!ost_bits_q[i]) free_ptr = PTR_WIDTH'(i);
        end
    end

    assign req_ready  = ~&ost_bits_q;
    assign req_ptr    = free_ptr;
    assign alloc      = req_valid && req_ready;
    assign beat_acc   = resp_valid && resp_ready && ost_bits_q[resp_ptr];
    assign release_ev = beat_acc && resp_last;

    // Alloc hits a clear bit and release a set bit, so they never collide.
    always_comb begin
        ost_bits_d = ost_bits_q;
        if (release_ev) ost_bits_d[resp_ptr] = 1'b0;
        if (alloc)      ost_bits_d[free_ptr] = 1'b1;
        ost_cnt_d = ost_cnt_q;
        if (alloc && !release_ev)      ost_cnt_d = ost_cnt_q + 1'b1;
        else if (!alloc && release_ev) ost_cnt_d = ost_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ost_bits_q <= '0;
            ost_cnt_q  <= '0;
        end else begin
            ost_bits_q <= ost_bits_d;
            ost_cnt_q  <= ost_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) slot_id_q[free_ptr] <= req_id;
    end

    assign ost_bits = ost_bits_q;
    assign ost_cnt  = ost_cnt_q;
    assign slot_id  = slot_id_q[resp_ptr];

`ifdef EASYAXI_OST_ALLOC_LEN_CHECK_EN
    logic [LEN_WIDTH-1:0] slot_len_q [OST_DEPTH];
    logic [LEN_WIDTH-1:0] beat_cnt_q [OST_DEPTH];
    logic                 len_err_q;

    always_ff @(posedge clk) begin
        if (alloc) slot_len_q[free_ptr] <= req_len;
    end

    // Overrun saturates the counter so the final last beat still compares sanely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OST_DEPTH; i++) beat_cnt_q[i] <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (beat_acc) begin
                if (resp_last) begin
                    beat_cnt_q[resp_ptr] <= '0;
                    if (beat_cnt_q[resp_ptr] != slot_len_q[resp_ptr]) len_err_q <= 1'b1;
                end else if (beat_cnt_q[resp_ptr] == slot_len_q[resp_ptr]) begin
                    len_err_q <= 1'b1;
                end else begin
                    beat_cnt_q[resp_ptr] <= beat_cnt_q[resp_ptr] + 1'b1;
                end
            end
            if (alloc) beat_cnt_q[free_ptr] <= '0;
        end
    end

    assign len_err = len_err_q;
`else
    logic unused_req_len;
    assign unused_req_len = ^req_len;
    assign len_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/easyaxi_ost_alloc.md
Name: easyaxi_ost_alloc

Overview:
- Outstanding-transaction slot allocator upstream of the per-ID order tracker.
- Keeps a bitmap of OST_DEPTH slots and hands out the lowest free slot index as req_ptr on each request handshake. The order tracker queues that pointer per ID.
- Releases a slot when the tracker returns the pointer (resp_ptr) on the last-beat response handshake.
- Provides occupancy count and allocated bitmap for master-side flow control.

Parameters:
- OST_DEPTH, 16, number of outstanding slots; power of two, >=2.
- ID_WIDTH, 4, AXI ID width (stored per slot for debug/readback).
- LEN_WIDTH, 8, AXI burst length field width (AxLEN, beats-1).
- Derived: PTR_WIDTH = $clog2(OST_DEPTH); CNT_WIDTH = PTR_WIDTH+1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  master presents a new AR/AW request.
- req_id  in  ID_WIDTH  request ID, stored in allocated slot.
- req_len  in  LEN_WIDTH  request AxLEN, stored in allocated slot.
- req_ready  out  1  at least one slot free.
- req_ptr  out  PTR_WIDTH  slot index granted on handshake.
- resp_valid  in  1  response beat valid.
- resp_ready  in  1  response beat accepted.
- resp_ptr  in  PTR_WIDTH  slot index of this response, from the order tracker.
- resp_last  in  1  last beat of the burst.
- ost_bits  out  OST_DEPTH  registered allocated-slot bitmap.
- ost_cnt  out  CNT_WIDTH  registered count of allocated slots, 0..OST_DEPTH.
- slot_id  out  ID_WIDTH  stored ID of slot resp_ptr (combinational readback).
- len_err  out  1  burst-length mismatch pulse (optional feature).

Behaviour:
- Reset (async assert, sync deassert at the system level):
  - ost_bits=0, ost_cnt=0, all beat counters=0, len_err=0.
  - After reset, req_ready=1 and req_ptr=0.
- Allocation:
  - req_ready = ~&ost_bits, taken from registers only, independent of req_valid.
  - req_ptr = index of the lowest zero bit in ost_bits; value is 0 when full (don't-care).
  - Handshake = req_valid && req_ready. On the next edge: ost_bits[req_ptr]<=1, slot_id_q<=req_id, slot_len_q<=req_len, beat_cnt<=0.
- Release:
  - Free event = resp_valid && resp_ready && resp_last && ost_bits[resp_ptr].
  - On the next edge: ost_bits[resp_ptr]<=0.
  - A response to an unallocated slot is ignored: no state change, no error.
- Beat counting:
  - Each accepted response beat to an allocated slot with resp_last=0 increments beat_cnt[resp_ptr].
  - A free event clears beat_cnt[resp_ptr].
- Latency:
  - A freed slot becomes allocatable on the cycle after the free edge.
  - There is no same-cycle bypass from release to allocation.
- Simultaneous alloc and free:
  - Both apply and ost_cnt is unchanged.
  - They can never target the same slot, because an alloc targets a zero bit and a free targets a one bit.
- ost_cnt: +1 on alloc only, -1 on free only, hold otherwise. It never wraps; allocating when full is impossible because req_ready=0.
- Full: ost_cnt==OST_DEPTH, req_ready=0. A free on that cycle makes req_ready=1 in the following cycle.
- Empty: a response with any resp_ptr is ignored.
- Reset mid-operation: all slots free immediately; in-flight responses after reset are ignored.
- slot_id = slot_id_q[resp_ptr], combinational.

Optional Feature:
- Macro: EASYAXI_OST_ALLOC_LEN_CHECK_EN.
- Defined:
  - On a free event, len_err is registered 1 for exactly one cycle if beat_cnt[resp_ptr] != slot_len_q[resp_ptr] (early last).
  - It also pulses if a non-last beat arrives with beat_cnt[resp_ptr]==slot_len_q[resp_ptr] (overrun). In that case beat_cnt saturates and does not wrap.
- Not defined:
  - len_err is tied 0.
  - slot_len_q and beat_cnt storage are removed.
  - req_len is unused.

Test Plan:
- Reset, then 3 handshakes with ids 1,2,1 -> req_ptr 0,1,2; ost_bits=0x0007; ost_cnt=3.
- Fill all 16 slots -> req_ready=0 and ost_cnt=16. A free of resp_ptr=5 with resp_last -> req_ready=1 next cycle, req_ptr=5, ost_bits=0xFFDF.
- Same cycle: alloc (grants ptr 3) and free of ptr 0 from state 0x0007 -> ost_bits=0x000E, ost_cnt stays 3.
- Free with resp_ptr=9 while slot 9 unallocated -> ost_bits and ost_cnt unchanged, len_err=0.
- With EASYAXI_OST_ALLOC_LEN_CHECK_EN, req_len=3:
  - 4 beats, last on the 4th -> len_err stays 0.
  - Repeat with last on the 2nd beat -> len_err=1 for one cycle and the slot is freed.
- Assert rst_n low with ost_cnt=7 -> ost_bits=0, ost_cnt=0, req_ptr=0 immediately; the first post-reset handshake gets ptr 0.
